// File: rtl/abr_params_pkg.sv
// Shared parameters for the ABR vector add/sub sequencer.
//   REG_SIZE_DEF  : default coefficient width in bits
//   NUM_COEFF_DEF : default number of coefficients per vector operation
//   abr_state_e   : sequencer state encoding
package abr_params_pkg;

    localparam int unsigned REG_SIZE_DEF  = 24;
    localparam int unsigned NUM_COEFF_DEF = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_EX    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } abr_state_e;

endpackage

// File: rtl/abr_addsub_seq.sv
// Vector add/subtract sequencer. Streams NUM_COEFF operand pairs from memory
// into an external modular add/sub unit and writes its results back.
//
// state | meaning
// IDLE  | waiting for start_i
// RD    | read strobe for coefficient rd_cnt
// EX    | issue operands of rd_cnt to the add/sub unit
// DRAIN | all issued, waiting for the last result write
// DONE  | one-cycle completion pulse
//
// Ports:
//   clk, reset_n (async, active-low), zeroize (sync clear)
//   start_i, sub_mode_i             : operation request / mode (1 = subtract)
//   rd_en_o, rd_addr_o              : operand memory read
//   rd_data_a_i, rd_data_b_i        : operands, valid the cycle after rd_en_o
//   add_en_o, sub_o, opa_o, opb_o   : issue to modular add/sub unit
//   res_i, ready_i                  : result from modular add/sub unit
//   wr_en_o, wr_addr_o, wr_data_o   : result memory write
//   busy_o, done_o                  : status
module abr_addsub_seq
    import abr_params_pkg::*;
#(
    parameter int REG_SIZE  = REG_SIZE_DEF,
    parameter int NUM_COEFF = NUM_COEFF_DEF,
    parameter int ADDR_W    = $clog2(NUM_COEFF)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                zeroize,
    input  logic                start_i,
    input  logic                sub_mode_i,
    output logic                rd_en_o,
    output logic [ADDR_W-1:0]   rd_addr_o,
    input  logic [REG_SIZE-1:0] rd_data_a_i,
    input  logic [REG_SIZE-1:0] rd_data_b_i,
    output logic                add_en_o,
    output logic                sub_o,
    output logic [REG_SIZE-1:0] opa_o,
    output logic [REG_SIZE-1:0] opb_o,
    input  logic [REG_SIZE-1:0] res_i,
    input  logic                ready_i,
    output logic                wr_en_o,
    output logic [ADDR_W-1:0]   wr_addr_o,
    output logic [REG_SIZE-1:0] wr_data_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_COEFF - 1);

    abr_state_e        state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              active;
    logic              wr_fire;

    // Results are only accepted while an operation is in flight.
    assign active  = (state_q == ST_RD) || (state_q == ST_EX) || (state_q == ST_DRAIN);
    assign wr_fire = ready_i && active && !zeroize;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_RD;
                    mode_d   = sub_mode_i;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                end
            end
            ST_RD: state_d = ST_EX;
            ST_EX: begin
                rd_cnt_d = (rd_cnt_q == LAST) ? '0 : rd_cnt_q + ADDR_W'(1);
                state_d  = (rd_cnt_q == LAST) ? ST_DRAIN : ST_RD;
            end
            ST_DRAIN: begin
                if (wr_fire && (wr_cnt_q == LAST)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                mode_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
        if (wr_fire) begin
            wr_cnt_d = (wr_cnt_q == LAST) ? '0 : wr_cnt_q + ADDR_W'(1);
        end
        if (zeroize) begin
            state_d  = ST_IDLE;
            mode_d   = 1'b0;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end
    end

    // Every output is forced low during zeroize so nothing leaks out in the
    // clearing cycle.
    always_comb begin
        rd_en_o   = 1'b0;
        rd_addr_o = '0;
        add_en_o  = 1'b0;
        sub_o     = 1'b0;
        opa_o     = '0;
        opb_o     = '0;
        wr_en_o   = 1'b0;
        wr_addr_o = '0;
        wr_data_o = '0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        if (!zeroize) begin
            busy_o = (state_q != ST_IDLE);
            sub_o  = (state_q != ST_IDLE) && mode_q;
            if (state_q == ST_RD) begin
                rd_en_o   = 1'b1;
                rd_addr_o = rd_cnt_q;
            end
            // RD/EX alternate, so issues are naturally spaced two cycles apart.
            if (state_q == ST_EX) begin
                add_en_o = 1'b1;
                opa_o    = rd_data_a_i;
                opb_o    = rd_data_b_i;
            end
            if (wr_fire) begin
                wr_en_o   = 1'b1;
                wr_addr_o = wr_cnt_q;
                wr_data_o = res_i;
            end
            done_o = (state_q == ST_DONE);
        end
    end

endmodule

// File: tb/tb_abr_addsub_seq.sv
module tb_abr_addsub_seq;

    localparam int  RS  = 24;
    localparam int  N   = 256;
    localparam int  AW  = 8;
    localparam longint Q = 8380417;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          zeroize = 1'b0;
    logic          start_i = 1'b0;
    logic          sub_mode_i = 1'b0;
    logic          rd_en_o;
    logic [AW-1:0] rd_addr_o;
    logic [RS-1:0] rd_data_a_i, rd_data_b_i;
    logic          add_en_o, sub_o;
    logic [RS-1:0] opa_o, opb_o;
    logic [RS-1:0] res_i;
    logic          ready_i;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [RS-1:0] wr_data_o;
    logic          busy_o, done_o;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [RS-1:0] mem_a [N];
    logic [RS-1:0] mem_b [N];

    logic          p_vld, rdy, spur_rdy = 1'b0;
    logic [RS-1:0] p_res;

    int wlog_addr[$], wlog_data[$], wlog_cyc[$];
    int done_cyc = -1, done_cnt = 0, add_viol = 0, last_add = -10;

    abr_addsub_seq #(.REG_SIZE(RS), .NUM_COEFF(N), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
        .start_i(start_i), .sub_mode_i(sub_mode_i),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
        .rd_data_a_i(rd_data_a_i), .rd_data_b_i(rd_data_b_i),
        .add_en_o(add_en_o), .sub_o(sub_o), .opa_o(opa_o), .opb_o(opb_o),
        .res_i(res_i), .ready_i(ready_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Operand memories: registered read, data valid the cycle after rd_en_o.
    always @(posedge clk) begin
        if (rd_en_o) begin
            rd_data_a_i <= mem_a[rd_addr_o];
            rd_data_b_i <= mem_b[rd_addr_o];
        end
    end

    // Modular add/sub unit with two-cycle issue-to-ready latency.
    function automatic logic [RS-1:0] modunit(logic [RS-1:0] a, logic [RS-1:0] b, logic s);
        logic [RS:0] t;
        if (s) t = (a >= b) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + RS'(Q) - {1'b0, b};
        else begin
            t = {1'b0, a} + {1'b0, b};
            if (t >= (RS+1)'(Q)) t = t - (RS+1)'(Q);
        end
        return t[RS-1:0];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_vld <= 1'b0; p_res <= '0; rdy <= 1'b0; res_i <= '0;
        end else begin
            p_vld <= add_en_o;
            p_res <= modunit(opa_o, opb_o, sub_o);
            rdy   <= p_vld;
            res_i <= p_res;
        end
    end
    assign ready_i = rdy | spur_rdy;

    always @(negedge clk) begin
        if (reset_n) begin
            if (wr_en_o) begin
                wlog_addr.push_back(int'(wr_addr_o));
                wlog_data.push_back(int'(wr_data_o));
                wlog_cyc.push_back(cyc);
            end
            if (done_o) begin
                done_cyc = cyc;
                done_cnt = done_cnt + 1;
            end
            if (add_en_o) begin
                if (last_add == cyc - 1) add_viol = add_viol + 1;
                last_add = cyc;
            end
        end
    end

    // Reference: plain modular arithmetic on the stored operands.
    function automatic longint model(longint a, longint b, bit s);
        longint r;
        r = s ? (a - b) : (a + b);
        return ((r % Q) + Q) % Q;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wlog_addr.delete(); wlog_data.delete(); wlog_cyc.delete();
        done_cyc = -1; done_cnt = 0; add_viol = 0; last_add = -10;
    endtask

    task automatic fill(input int kind);
        for (int k = 0; k < N; k++) begin
            case (kind)
                0: begin mem_a[k] = RS'(k); mem_b[k] = RS'(2*k); end
                1: begin mem_a[k] = RS'(8380416); mem_b[k] = RS'(8380416); end
                default: begin
                    mem_a[k] = RS'($urandom_range(0, 8380416));
                    mem_b[k] = RS'($urandom_range(0, 8380416));
                end
            endcase
        end
    endtask

    task automatic start_op(input bit mode, output int t0);
        @(posedge clk); #1;
        sub_mode_i = mode; start_i = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start_i = 1'b0; sub_mode_i = 1'b0;
    endtask

    // Runs a full operation and checks every write against the model.
    task automatic run_op(input bit mode, input int extra_start, input string tag);
        int t0, n;
        clear_logs();
        start_op(mode, t0);
        n = 0;
        while (done_cnt == 0 && n < 2000) begin
            if (extra_start > 0 && cyc == t0 + extra_start) begin
                start_i = 1'b1; sub_mode_i = ~mode;
                @(posedge clk); #1;
                start_i = 1'b0; sub_mode_i = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_done_seen"}, done_cnt, 1);
        chk({tag, "_done_cycle"}, done_cyc - t0, 2*N + 3);
        chk({tag, "_write_count"}, wlog_addr.size(), N);
        chk({tag, "_issue_spacing"}, add_viol, 0);
        chk({tag, "_busy_after"}, busy_o, 0);
        if (wlog_addr.size() == N) begin
            for (int k = 0; k < N; k++) begin
                chk($sformatf("%s_addr[%0d]", tag, k), wlog_addr[k], k);
                chk($sformatf("%s_data[%0d]", tag, k), wlog_data[k],
                    model(longint'(mem_a[k]), longint'(mem_b[k]), mode));
                chk($sformatf("%s_wcyc[%0d]", tag, k), wlog_cyc[k] - t0, 2*k + 4);
            end
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, rd_en_o, 0);
        chk({tag, "_rd_addr"}, rd_addr_o, 0);
        chk({tag, "_add_en"}, add_en_o, 0);
        chk({tag, "_sub"}, sub_o, 0);
        chk({tag, "_opa"}, opa_o, 0);
        chk({tag, "_opb"}, opb_o, 0);
        chk({tag, "_wr_en"}, wr_en_o, 0);
        chk({tag, "_wr_addr"}, wr_addr_o, 0);
        chk({tag, "_wr_data"}, wr_data_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
    endtask

    initial begin
        int t0, nw;
        for (int k = 0; k < N; k++) begin mem_a[k] = '0; mem_b[k] = '0; end
        rd_data_a_i = '0; rd_data_b_i = '0;
        #3;
        chk_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // Add ramp: a=k, b=2k -> 3k.
        fill(0);
        run_op(1'b0, 0, "add_ramp");
        if (wlog_data.size() == N) chk("add_ramp_k255", wlog_data[255], 765);

        // Subtract with directed wrap-around values at the first two addresses.
        fill(2);
        mem_a[0] = RS'(5); mem_b[0] = RS'(7);
        mem_a[1] = RS'(7); mem_b[1] = RS'(5);
        run_op(1'b1, 0, "sub");
        if (wlog_data.size() == N) begin
            chk("sub_addr0", wlog_data[0], 8380415);
            chk("sub_addr1", wlog_data[1], 2);
        end

        // Maximum operands: (q-1)+(q-1) mod q = q-2.
        fill(1);
        run_op(1'b0, 0, "add_max");

        // Random add, with a stray start (opposite mode) at cycle 100.
        fill(2);
        run_op(1'b0, 100, "add_rand_start100");

        // Random subtract.
        fill(2);
        run_op(1'b1, 0, "sub_rand");

        // Zeroize at cycle 50 of a running operation.
        fill(2);
        clear_logs();
        start_op(1'b0, t0);
        while (cyc < t0 + 50) begin @(posedge clk); #1; end
        zeroize = 1'b1;
        nw = wlog_addr.size();
        #1;
        chk("zeroize_wr_en", wr_en_o, 0);
        @(posedge clk); #1;
        zeroize = 1'b0;
        chk("zeroize_busy_next", busy_o, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("zeroize_no_writes", wlog_addr.size() - nw, 0);
        chk("zeroize_no_done", done_cnt, 0);
        run_op(1'b0, 0, "after_zeroize");

        // Asynchronous reset mid-operation.
        fill(2);
        start_op(1'b1, t0);
        repeat (30) @(posedge clk);
        #3 reset_n = 1'b0;
        #1 chk_outputs_zero("midop_reset");
        @(posedge clk); #2 reset_n = 1'b1;

        // Spurious ready_i in IDLE must not write.
        @(posedge clk); #1;
        spur_rdy = 1'b1;
        #1 chk("spur_ready_wr_en0", wr_en_o, 0);
        @(posedge clk); #1;
        chk("spur_ready_wr_en1", wr_en_o, 0);
        spur_rdy = 1'b0;

        // First start after reset behaves like any other.
        fill(2);
        run_op(1'b1, 0, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/abr_addsub_seq.md
ABR_ADDSUB_SEQ -- requirements
Module: abr_addsub_seq

Interface
REQ-001 Parameter REG_SIZE, default 24: coefficient width in bits.
REQ-002 Parameter NUM_COEFF, default 256: coefficients per vector operation.
REQ-003 Parameter ADDR_W, default 8: memory address width; it SHALL equal clog2(NUM_COEFF).
REQ-004 clk  in  1  clock.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 zeroize  in  1  synchronous clear.
REQ-007 start_i  in  1  one-cycle pulse that begins a vector operation.
REQ-008 sub_mode_i  in  1  operation select, sampled with start_i: 1 = subtract, 0 = add.
REQ-009 rd_en_o  out  1  operand memory read strobe.
REQ-010 rd_addr_o  out  ADDR_W  operand read address.
REQ-011 rd_data_a_i, rd_data_b_i  in  REG_SIZE each  operands, valid the cycle after rd_en_o.
REQ-012 add_en_o  out  1  issue pulse to the modular add/sub unit.
REQ-013 sub_o  out  1  operation select to the modular add/sub unit.
REQ-014 opa_o, opb_o  out  REG_SIZE each  operands to the modular add/sub unit.
REQ-015 res_i  in  REG_SIZE  result from the modular add/sub unit.
REQ-016 ready_i  in  1  result-valid strobe from the modular add/sub unit.
REQ-017 wr_en_o  out  1  result write strobe.
REQ-018 wr_addr_o  out  ADDR_W  result write address.
REQ-019 wr_data_o  out  REG_SIZE  result write data.
REQ-020 busy_o  out  1  high from the cycle after an accepted start until the cycle done_o pulses.
REQ-021 done_o  out  1  one-cycle completion pulse.

Function
REQ-022 The FSM SHALL have states IDLE, RD, EX, DRAIN and DONE.
REQ-023 IDLE -> RD when start_i=1; the block SHALL latch sub_mode_i and clear the read and write counters.
REQ-024 In RD, rd_en_o=1 and rd_addr_o=rd_cnt; next state is EX.
REQ-025 In EX:
- add_en_o=1, opa_o=rd_data_a_i, opb_o=rd_data_b_i;
- rd_cnt increments;
- next state is RD, or DRAIN if rd_cnt was NUM_COEFF-1.
REQ-026 The block SHALL issue at most one add_en_o every 2 cycles, because the responder overwrites its result if issued on consecutive cycles.
REQ-027 sub_o SHALL equal the latched mode for the entire operation.
REQ-028 When ready_i=1 while busy, the block SHALL drive, in that same cycle:
- wr_en_o=1;
- wr_data_o=res_i;
- wr_addr_o=wr_cnt;
- wr_cnt increments after the write.
REQ-029 ready_i while in IDLE or DONE SHALL be ignored.
REQ-030 DRAIN -> DONE on the write of address NUM_COEFF-1.
REQ-031 DONE SHALL assert done_o for one cycle, then return to IDLE.
REQ-032 Timing, with start accepted in cycle 0:
- add_en_o for coefficient k in cycle 2k+2;
- write of k in cycle 2k+4;
- done_o in cycle 2*NUM_COEFF+3 (515 for the default).
REQ-033 start_i while busy_o=1 SHALL be ignored with no effect on state or counters.
REQ-034 Both counters are ADDR_W wide and SHALL wrap to 0 after NUM_COEFF-1.
REQ-035 zeroize SHALL override all other inputs: state returns to IDLE and all registers clear, including mid-operation; no write occurs in that cycle.
REQ-036 All outputs SHALL be 0 whenever they are not being asserted per REQ-024..REQ-031.

Reset
REQ-037 On reset_n=0, the state SHALL be IDLE and all registers, counters and outputs SHALL be 0, asynchronously.
REQ-038 After reset release, the first accepted start SHALL behave identically to any later start.

Structure
REQ-039 The state enum typedef and the default REG_SIZE/NUM_COEFF constants SHALL reside in the shared package abr_params_pkg.
REQ-040 The block SHALL have no sub-module.
REQ-041 The modular add/sub unit and the memories SHALL be connected at the parent level.

Verification
REQ-042 Add: a[k]=k, b[k]=2k, q=8380417, NUM_COEFF=256 -> wr_data=3k at wr_addr=k; done_o at cycle 515.
REQ-043 Subtract: a[0]=5, b[0]=7 -> wr_data at address 0 = 8380415; a[1]=7, b[1]=5 -> 2.
REQ-044 Add with a=b=8380416 at every address -> every write = 8380415.
REQ-045 start_i pulsed at cycle 100 of a running operation -> no change to write count (256) or to done_o timing.
REQ-046 zeroize at cycle 50 -> busy_o=0 next cycle, no further writes; a following start completes a full 256-write run correctly.
REQ-047 reset_n asserted mid-operation -> all outputs 0 immediately; spurious ready_i in IDLE -> wr_en_o stays 0.
